// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter that applies one gate car event at a time to shared occupancy counters.
// Latency: grant on the first req edge, done/accepted one edge later for one cycle; one event per 3 cycles, no backpressure.
module parking_gate_arbiter #(
    parameter int NUM_GATES = 4,
    parameter int CNT_W     = 11,
    parameter int IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_GATES-1:0] req,
    input  logic [NUM_GATES-1:0] is_entry,
    input  logic [NUM_GATES-1:0] is_uni,
    input  logic [CNT_W-1:0]     uni_capacity,
    input  logic [CNT_W-1:0]     capacity,
    output logic [NUM_GATES-1:0] done,
    output logic                 accepted,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_idx,
    output logic [CNT_W-1:0]     uni_parked_car,
    output logic [CNT_W-1:0]     parked_car,
    output logic [CNT_W-1:0]     uni_vacated_space,
    output logic [CNT_W-1:0]     vacated_space,
    output logic                 uni_is_vacated_space,
    output logic                 is_vacated_space
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic                   entry_q, entry_d;
    logic                   uni_q, uni_d;
    logic [NUM_GATES-1:0]   done_q, done_d;
    logic                   accepted_q, accepted_d;
    logic [CNT_W-1:0]       uni_park_q, uni_park_d;
    logic [CNT_W-1:0]       park_q, park_d;

    logic                   found;
    logic [IDX_W-1:0]       pick;
    logic [IDX_W:0]         cand;
    logic [IDX_W:0]         nxt;
    logic                   acc;
    logic [CNT_W:0]         uni_diff;
    logic [CNT_W:0]         diff;

    // Rotating search: first requesting gate at or above the rr pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            cand = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_GATES)) begin
                cand = cand - (IDX_W+1)'(NUM_GATES);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        nxt = {1'b0, grant_idx_q} + (IDX_W+1)'(1);
        if (nxt >= (IDX_W+1)'(NUM_GATES)) begin
            nxt = '0;
        end
    end

    // Entry needs room under the live capacity; exit needs a car to remove, so counters never wrap.
    always_comb begin
        if (entry_q) begin
            acc = uni_q ? (uni_park_q < uni_capacity) : (park_q < capacity);
        end else begin
            acc = uni_q ? (uni_park_q != '0) : (park_q != '0);
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_idx_d = grant_idx_q;
        entry_d     = entry_q;
        uni_d       = uni_q;
        done_d      = done_q;
        accepted_d  = accepted_q;
        uni_park_d  = uni_park_q;
        park_d      = park_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_idx_d = pick;
                    entry_d     = is_entry[pick];
                    uni_d       = is_uni[pick];
                    state_d     = S_GRANT;
                end
            end
            S_GRANT: begin
                done_d              = '0;
                done_d[grant_idx_q] = 1'b1;
                accepted_d          = acc;
                if (acc) begin
                    if (uni_q) begin
                        uni_park_d = entry_q ? (uni_park_q + CNT_W'(1)) : (uni_park_q - CNT_W'(1));
                    end else begin
                        park_d = entry_q ? (park_q + CNT_W'(1)) : (park_q - CNT_W'(1));
                    end
                end
                rr_d    = nxt[IDX_W-1:0];
                state_d = S_RESP;
            end
            S_RESP: begin
                done_d     = '0;
                accepted_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            grant_idx_q <= '0;
            entry_q     <= 1'b0;
            uni_q       <= 1'b0;
            done_q      <= '0;
            accepted_q  <= 1'b0;
            uni_park_q  <= '0;
            park_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_idx_q <= grant_idx_d;
            entry_q     <= entry_d;
            uni_q       <= uni_d;
            done_q      <= done_d;
            accepted_q  <= accepted_d;
            uni_park_q  <= uni_park_d;
            park_q      <= park_d;
        end
    end

    // Extra bit turns capacity-below-occupancy into a negative result that clamps to zero.
    assign uni_diff = {1'b0, uni_capacity} - {1'b0, uni_park_q};
    assign diff     = {1'b0, capacity} - {1'b0, park_q};

    assign uni_vacated_space    = uni_diff[CNT_W] ? '0 : uni_diff[CNT_W-1:0];
    assign vacated_space        = diff[CNT_W] ? '0 : diff[CNT_W-1:0];
    assign uni_is_vacated_space = (uni_vacated_space != '0);
    assign is_vacated_space     = (vacated_space != '0);

    assign done           = done_q;
    assign accepted       = accepted_q;
    assign busy           = (state_q != S_IDLE);
    assign grant_idx      = grant_idx_q;
    assign uni_parked_car = uni_park_q;
    assign parked_car     = park_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: directed scenarios plus random gate traffic against a transaction-level model.
module tb_parking_gate_arbiter;

    localparam int N = 4;
    localparam int W = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_v, ent_v, uni_v;
    logic [W-1:0]  ucap_v, cap_v;
    logic [N-1:0]  done;
    logic          accepted, busy;
    logic [1:0]    grant_idx;
    logic [W-1:0]  uni_parked_car, parked_car, uni_vacated_space, vacated_space;
    logic          uni_is_vacated_space, is_vacated_space;

    always #5 clk = ~clk;

    parking_gate_arbiter #(.NUM_GATES(N), .CNT_W(W), .IDX_W(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req                  (req_v),
        .is_entry             (ent_v),
        .is_uni               (uni_v),
        .uni_capacity         (ucap_v),
        .capacity             (cap_v),
        .done                 (done),
        .accepted             (accepted),
        .busy                 (busy),
        .grant_idx            (grant_idx),
        .uni_parked_car       (uni_parked_car),
        .parked_car           (parked_car),
        .uni_vacated_space    (uni_vacated_space),
        .vacated_space        (vacated_space),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // Transaction model: an event selected at edge c completes at edge c+1, server free again at edge c+3.
    int cyc       = 0;
    int next_free = 0;
    int done_edge = -1;
    int m_g = 0, m_rr = 0, m_park = 0, m_upark = 0;
    bit m_e = 1'b0, m_u = 1'b0;
    int exp_done = 0, exp_acc = 0, exp_busy = 0, exp_gidx = 0;

    logic [N-1:0] rearm        = '0;
    logic [N-1:0] just_dropped = '0;
    bit           rand_on      = 1'b0;

    task automatic model_edge();
        bit ok;
        bit got;
        int j;
        if (rst) begin
            m_park = 0; m_upark = 0; m_rr = 0;
            next_free = cyc + 1; done_edge = -1;
            exp_done = 0; exp_acc = 0; exp_busy = 0; exp_gidx = 0;
            return;
        end
        exp_done = 0;
        exp_acc  = 0;
        if (cyc == done_edge) begin
            if (m_e) ok = m_u ? (m_upark < int'(ucap_v)) : (m_park < int'(cap_v));
            else     ok = m_u ? (m_upark > 0) : (m_park > 0);
            if (ok) begin
                if (m_u) m_upark += m_e ? 1 : -1;
                else     m_park  += m_e ? 1 : -1;
            end
            exp_done = 1 << m_g;
            exp_acc  = ok ? 1 : 0;
        end
        if (cyc >= next_free && req_v != '0) begin
            got = 1'b0;
            for (int i = 0; i < N; i++) begin
                j = (m_rr + i) % N;
                if (!got && req_v[j]) begin
                    got = 1'b1;
                    m_g = j; m_e = ent_v[j]; m_u = uni_v[j];
                end
            end
            m_rr      = (m_g + 1) % N;
            exp_gidx  = m_g;
            done_edge = cyc + 1;
            next_free = cyc + 3;
        end
        exp_busy = (cyc < next_free - 1) ? 1 : 0;
    endtask

    task automatic compare();
        int vac, uvac;
        vac  = int'(cap_v) - m_park;   if (vac < 0)  vac = 0;
        uvac = int'(ucap_v) - m_upark; if (uvac < 0) uvac = 0;
        check_eq("done",       int'(done),              exp_done);
        check_eq("accepted",   int'(accepted),          exp_acc);
        check_eq("busy",       int'(busy),              exp_busy);
        check_eq("grant_idx",  int'(grant_idx),         exp_gidx);
        check_eq("parked",     int'(parked_car),        m_park);
        check_eq("uni_parked", int'(uni_parked_car),    m_upark);
        check_eq("vacant",     int'(vacated_space),     vac);
        check_eq("uni_vacant", int'(uni_vacated_space), uvac);
        check_eq("vac_flag",   int'(is_vacated_space),  (vac != 0) ? 1 : 0);
        check_eq("uvac_flag",  int'(uni_is_vacated_space), (uvac != 0) ? 1 : 0);
    endtask

    // One clock: model at the edge, checks and gate reactions at the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare();
        for (int g = 0; g < N; g++) begin
            if (rearm[g] && just_dropped[g]) req_v[g] = 1'b1;
        end
        just_dropped = done;
        req_v = req_v & ~done;
        if (rand_on) begin
            for (int g = 0; g < N; g++) begin
                if (!req_v[g] && !done[g] && $urandom_range(0, 3) == 0) begin
                    req_v[g] = 1'b1;
                    ent_v[g] = 1'($urandom_range(0, 1));
                    uni_v[g] = 1'($urandom_range(0, 1));
                end
            end
            if ($urandom_range(0, 15) == 0) cap_v  = W'($urandom_range(0, 10));
            if ($urandom_range(0, 15) == 0) ucap_v = W'($urandom_range(0, 10));
            rst = ($urandom_range(0, 299) == 0);
        end
    endtask

    task automatic wait_done(output int idx);
        idx = -1;
        for (int k = 0; k < 40 && idx < 0; k++) begin
            tick();
            for (int g = 0; g < N; g++) if (done[g]) idx = g;
        end
        if (idx < 0) check_eq("done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int idx;
        int ord[4];
        int dc[4];
        int acc3[3];
        int seq[6];
        rst = 1'b1; req_v = '0; ent_v = '0; uni_v = '0;
        ucap_v = W'(500); cap_v = W'(100);
        tick(); tick();
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        rst = 1'b0;

        // Single university entry
        req_v[0] = 1'b1; ent_v[0] = 1'b1; uni_v[0] = 1'b1;
        wait_done(idx);
        check_eq("t1_idx", idx, 0);
        check_eq("t1_acc", int'(accepted), 1);
        check_eq("t1_upark", int'(uni_parked_car), 1);
        check_eq("t1_uvac", int'(uni_vacated_space), 499);
        tick();
        check_eq("t1_busy_after", int'(busy), 0);

        // All four gates at once, public entries
        do_reset();
        req_v = 4'hF; ent_v = 4'hF; uni_v = 4'h0;
        for (int q = 0; q < 4; q++) begin
            wait_done(idx);
            ord[q] = idx; dc[q] = cyc;
        end
        for (int q = 0; q < 4; q++) check_eq("t2_order", ord[q], q);
        for (int q = 1; q < 4; q++) check_eq("t2_spacing", dc[q] - dc[q-1], 3);
        check_eq("t2_parked", int'(parked_car), 4);

        // Public capacity limit
        do_reset();
        cap_v = W'(2); rearm = 4'b0001;
        req_v[0] = 1'b1; ent_v[0] = 1'b1; uni_v[0] = 1'b0;
        for (int q = 0; q < 3; q++) begin
            wait_done(idx);
            acc3[q] = int'(accepted);
        end
        rearm = '0;
        check_eq("t3_acc0", acc3[0], 1);
        check_eq("t3_acc1", acc3[1], 1);
        check_eq("t3_acc2", acc3[2], 0);
        check_eq("t3_parked", int'(parked_car), 2);
        check_eq("t3_vac", int'(vacated_space), 0);
        check_eq("t3_vflag", int'(is_vacated_space), 0);

        // University exit on empty, then exit with capacity below occupancy
        ucap_v = W'(500);
        tick();
        req_v[1] = 1'b1; ent_v[1] = 1'b0; uni_v[1] = 1'b1;
        wait_done(idx);
        check_eq("t4_exit_rej", int'(accepted), 0);
        check_eq("t4_upark0", int'(uni_parked_car), 0);
        tick();
        ent_v[1] = 1'b1; req_v[1] = 1'b1; rearm = 4'b0010;
        for (int q = 0; q < 3; q++) wait_done(idx);
        rearm = '0;
        tick(); tick();
        ucap_v = W'(1);
        tick();
        check_eq("t4_uvac0", int'(uni_vacated_space), 0);
        check_eq("t4_uflag0", int'(uni_is_vacated_space), 0);
        ent_v[1] = 1'b0; req_v[1] = 1'b1;
        wait_done(idx);
        check_eq("t4_exit_acc", int'(accepted), 1);
        check_eq("t4_upark2", int'(uni_parked_car), 2);

        // Fairness between a hog on gate 1 and gate 2
        do_reset();
        cap_v = W'(2047); ent_v = 4'b0110; uni_v = '0;
        rearm = 4'b0110; req_v = 4'b0110;
        for (int q = 0; q < 6; q++) begin
            wait_done(idx);
            seq[q] = idx;
        end
        rearm = '0;
        for (int q = 0; q < 6; q++) check_eq("t5_alt", seq[q], (q % 2 == 0) ? 1 : 2);
        for (int k = 0; k < 4 && req_v != '0; k++) wait_done(idx);
        tick(); tick();

        // Reset while in the grant state
        do_reset();
        req_v[1] = 1'b1; ent_v[1] = 1'b1; uni_v[1] = 1'b0;
        wait_done(idx);
        tick(); tick();
        req_v = 4'b1010; ent_v[3] = 1'b1; uni_v[3] = 1'b0;
        for (int k = 0; k < 10 && !busy; k++) tick();
        check_eq("t6_busy", int'(busy), 1);
        check_eq("t6_gidx3", int'(grant_idx), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_done0", int'(done), 0);
        check_eq("t6_park0", int'(parked_car), 0);
        check_eq("t6_gidx0", int'(grant_idx), 0);
        wait_done(idx);
        check_eq("t6_regrant", idx, 1);
        wait_done(idx);
        check_eq("t6_next", idx, 3);

        // Random traffic with small capacities and occasional resets
        do_reset();
        rand_on = 1'b1;
        repeat (3000) tick();
        rand_on = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 200 && (req_v != '0 || busy); k++) tick();
        check_eq("drain", int'(req_v == '0 && !busy), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
